// File: rtl/fb_write_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : paint_fb_pkg
// Description : Shared state encodings, requester indices and defaults for
//               the framebuffer write scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package paint_fb_pkg;

  // Scheduler FSM encoding
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_WRITE = 2'd1;
  localparam state_t ST_CLEAR = 2'd2;

  // Requester indices
  localparam int NUM_REQ    = 3;
  localparam int REQ_PAINT  = 0;
  localparam int REQ_CURSOR = 1;
  localparam int REQ_PALETA = 2;

  // Pixel value written by the clear sweep unless overridden
  localparam logic [7:0] DEFAULT_CLEAR_COLOR = 8'h00;

  // Round-robin pointer after a grant to idx: (idx + 1) mod NUM_REQ
  function automatic logic [1:0] rr_next(input logic [1:0] idx);
    return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fb_write_sched_picker.sv
`default_nettype none
// ============================================================================
// Module      : fb_req_picker
// Description : Combinational winner select among the three pixel writers.
//               Fixed priority 0>1>2 by default; round-robin starting at the
//               pointer when RR_ARB_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module fb_req_picker
  import paint_fb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
`ifdef RR_ARB_EN
  input  logic [1:0]         rr_ptr,
`endif
  output logic [NUM_REQ-1:0] grant,
  output logic [1:0]         idx,
  output logic               valid
);

`ifdef RR_ARB_EN
  logic [1:0] order [NUM_REQ];

  // Rotate the search order so it begins at the pointer, take first hit
  always_comb begin
    order[0] = 2'd0;
    order[1] = 2'd1;
    order[2] = 2'd2;
    case (rr_ptr)
      2'd1: begin
        order[0] = 2'd1;
        order[1] = 2'd2;
        order[2] = 2'd0;
      end
      2'd2: begin
        order[0] = 2'd2;
        order[1] = 2'd0;
        order[2] = 2'd1;
      end
      default: begin
        order[0] = 2'd0;
        order[1] = 2'd1;
        order[2] = 2'd2;
      end
    endcase
    grant = '0;
    idx   = 2'd0;
    valid = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!valid && req[order[k]]) begin
        valid            = 1'b1;
        idx              = order[k];
        grant[order[k]]  = 1'b1;
      end
    end
  end
`else
  // Fixed priority: paint stroke over canvas cursor over palette cursor
  always_comb begin
    grant = '0;
    idx   = 2'd0;
    valid = 1'b0;
    if (req[REQ_PAINT]) begin
      valid             = 1'b1;
      idx               = 2'(REQ_PAINT);
      grant[REQ_PAINT]  = 1'b1;
    end else if (req[REQ_CURSOR]) begin
      valid             = 1'b1;
      idx               = 2'(REQ_CURSOR);
      grant[REQ_CURSOR] = 1'b1;
    end else if (req[REQ_PALETA]) begin
      valid             = 1'b1;
      idx               = 2'(REQ_PALETA);
      grant[REQ_PALETA] = 1'b1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: rtl/fb_write_sched.sv
`default_nettype none
// ============================================================================
// Module      : fb_write_sched
// Description : Schedules the single framebuffer write port between three
//               pixel writers and a full-canvas clear sweep. Converts (x,y)
//               to y*FB_W+x. Optional macro RR_ARB_EN selects round-robin
//               arbitration instead of fixed priority.
// Revision    : 1.0 - initial release
// ============================================================================
module fb_write_sched
  import paint_fb_pkg::*;
#(
  parameter int         FB_W        = 64,
  parameter int         FB_H        = 64,
  parameter int         ADDR_W      = 12,
  parameter logic [7:0] CLEAR_COLOR = DEFAULT_CLEAR_COLOR
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic [7:0]         x0,
  input  logic [7:0]         x1,
  input  logic [7:0]         x2,
  input  logic [7:0]         y0,
  input  logic [7:0]         y1,
  input  logic [7:0]         y2,
  input  logic [7:0]         d0,
  input  logic [7:0]         d1,
  input  logic [7:0]         d2,
  output logic [NUM_REQ-1:0] ack,
  input  logic               clear_start,
  output logic               clear_done,
  output logic               busy,
  output logic               err_oob,
  output logic               fb_we,
  output logic [ADDR_W-1:0]  fb_addr,
  output logic [7:0]         fb_wdata
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_W * FB_H - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                fb_we_q, fb_we_d;
  logic [ADDR_W-1:0]   fb_addr_q, fb_addr_d;
  logic [7:0]          fb_wdata_q, fb_wdata_d;
  logic [NUM_REQ-1:0]  ack_q, ack_d;
  logic                clear_done_q, clear_done_d;
  logic                busy_q, busy_d;
  logic                err_oob_q, err_oob_d;
`ifdef RR_ARB_EN
  logic [1:0]          rr_ptr_q, rr_ptr_d;
`endif

  logic [NUM_REQ-1:0]  pick_grant;
  logic [1:0]          pick_idx;
  logic                pick_valid;
  logic [7:0]          sel_x, sel_y, sel_d;
  logic                pick_oob;
  logic [ADDR_W-1:0]   lin_addr;
  logic                clear_last;

  fb_req_picker u_picker (
    .req    (req),
`ifdef RR_ARB_EN
    .rr_ptr (rr_ptr_q),
`endif
    .grant  (pick_grant),
    .idx    (pick_idx),
    .valid  (pick_valid)
  );

  // Route the winner's coordinates/data, range-check, then linearise
  always_comb begin
    sel_x = x0;
    sel_y = y0;
    sel_d = d0;
    case (pick_idx)
      2'd1: begin
        sel_x = x1;
        sel_y = y1;
        sel_d = d1;
      end
      2'd2: begin
        sel_x = x2;
        sel_y = y2;
        sel_d = d2;
      end
      default: begin
        sel_x = x0;
        sel_y = y0;
        sel_d = d0;
      end
    endcase
    pick_oob = (32'(sel_x) >= 32'(FB_W)) || (32'(sel_y) >= 32'(FB_H));
    lin_addr = ADDR_W'(sel_y) * ADDR_W'(FB_W) + ADDR_W'(sel_x);
  end

  // The final clear write is the one currently on the port at LAST_ADDR
  assign clear_last = fb_we_q && (fb_addr_q == LAST_ADDR);

  // State and output registers; reset aborts any sweep in progress
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      fb_we_q      <= 1'b0;
      fb_addr_q    <= '0;
      fb_wdata_q   <= '0;
      ack_q        <= '0;
      clear_done_q <= 1'b0;
      busy_q       <= 1'b0;
      err_oob_q    <= 1'b0;
`ifdef RR_ARB_EN
      rr_ptr_q     <= 2'd0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      fb_we_q      <= fb_we_d;
      fb_addr_q    <= fb_addr_d;
      fb_wdata_q   <= fb_wdata_d;
      ack_q        <= ack_d;
      clear_done_q <= clear_done_d;
      busy_q       <= busy_d;
      err_oob_q    <= err_oob_d;
`ifdef RR_ARB_EN
      rr_ptr_q     <= rr_ptr_d;
`endif
    end
  end

  // Next state: clear beats any request; a write always takes two cycles
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (clear_start) begin
          state_d = ST_CLEAR;
        end else if (pick_valid) begin
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: state_d = ST_IDLE;
      ST_CLEAR: begin
        if (clear_last) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Next values for the registered outputs, sweep counter and rr pointer
  always_comb begin
    fb_we_d      = 1'b0;
    ack_d        = '0;
    err_oob_d    = 1'b0;
    clear_done_d = 1'b0;
    fb_addr_d    = fb_addr_q;
    fb_wdata_d   = fb_wdata_q;
    busy_d       = busy_q;
    cnt_d        = cnt_q;
`ifdef RR_ARB_EN
    rr_ptr_d     = rr_ptr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (clear_start) begin
          busy_d = 1'b1;
          cnt_d  = '0;
        end else if (pick_valid) begin
          ack_d = pick_grant;
`ifdef RR_ARB_EN
          rr_ptr_d = rr_next(pick_idx);
`endif
          if (pick_oob) begin
            // Out-of-range coordinates are consumed but never written
            err_oob_d = 1'b1;
          end else begin
            fb_we_d    = 1'b1;
            fb_addr_d  = lin_addr;
            fb_wdata_d = sel_d;
          end
        end
      end
      ST_WRITE: begin
        busy_d = 1'b0;
      end
      ST_CLEAR: begin
        if (clear_last) begin
          clear_done_d = 1'b1;
          busy_d       = 1'b0;
        end else begin
          fb_we_d    = 1'b1;
          fb_addr_d  = cnt_q;
          fb_wdata_d = CLEAR_COLOR;
          cnt_d      = cnt_q + 1'b1;
        end
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  assign fb_we      = fb_we_q;
  assign fb_addr    = fb_addr_q;
  assign fb_wdata   = fb_wdata_q;
  assign ack        = ack_q;
  assign clear_done = clear_done_q;
  assign busy       = busy_q;
  assign err_oob    = err_oob_q;

endmodule
`default_nettype wire

// File: tb/tb_fb_write_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_fb_write_sched
// Description : Scoreboard bench for fb_write_sched. Expected framebuffer
//               writes are queued as stimulus is driven and compared as the
//               write port produces them. Honours RR_ARB_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fb_write_sched;

  typedef struct packed {
    logic [11:0] addr;
    logic [7:0]  data;
  } wr_t;

  logic        clk;
  logic        rst;
  logic [2:0]  req;
  logic [7:0]  xs [3];
  logic [7:0]  ys [3];
  logic [7:0]  ds [3];
  logic [2:0]  ack;
  logic        clear_start;
  logic        clear_done;
  logic        busy;
  logic        err_oob;
  logic        fb_we;
  logic [11:0] fb_addr;
  logic [7:0]  fb_wdata;

  int  n_checks = 0;
  int  n_errors = 0;
  wr_t exp_q[$];
  int  ptr = 0;

  fb_write_sched #(
    .FB_W(64), .FB_H(64), .ADDR_W(12), .CLEAR_COLOR(8'h00)
  ) dut (
    .clk(clk), .rst(rst), .req(req),
    .x0(xs[0]), .x1(xs[1]), .x2(xs[2]),
    .y0(ys[0]), .y1(ys[1]), .y2(ys[2]),
    .d0(ds[0]), .d1(ds[1]), .d2(ds[2]),
    .ack(ack), .clear_start(clear_start), .clear_done(clear_done),
    .busy(busy), .err_oob(err_oob), .fb_we(fb_we),
    .fb_addr(fb_addr), .fb_wdata(fb_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Winner model: fixed priority or round-robin from the bench's own pointer
  function automatic int pick(input logic [2:0] r, input int p);
`ifdef RR_ARB_EN
    for (int k = 0; k < 3; k++) begin
      int c;
      c = (p + k) % 3;
      if (r[c]) return c;
    end
`else
    for (int c = 0; c < 3; c++) begin
      if (r[c]) return c;
    end
`endif
    return -1;
  endfunction

  function automatic wr_t exp_of(input int w);
    wr_t e;
    e.addr = 12'(int'(ys[w]) * 64 + int'(xs[w]));
    e.data = ds[w];
    return e;
  endfunction

  task automatic wait_ack(output logic [2:0] a);
    a = 3'b000;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ack != 3'b000) begin
        a = ack;
        return;
      end
    end
    check("ack_timeout", 32'd0, 32'd1);
  endtask

  // Scoreboard consumer: every write on the port must match the queue head
  always @(negedge clk) begin
    if (fb_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_write", {20'd0, fb_addr}, 32'hFFFFFFFF);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("sb_addr", {20'd0, fb_addr}, {20'd0, e.addr});
        check("sb_data", {24'd0, fb_wdata}, {24'd0, e.data});
      end
    end
  end

  initial begin
    logic [2:0] a;
    logic [2:0] cur;
    int w;
    int nwr;
    bit done_seen;
    bit ack_in_clear;
    bit hit;

    rst = 1'b1; req = 3'b000; clear_start = 1'b0;
    for (int i = 0; i < 3; i++) begin xs[i] = 8'd0; ys[i] = 8'd0; ds[i] = 8'd0; end
    repeat (3) @(negedge clk);
    check("rst_fb_we", {31'd0, fb_we}, 32'd0);
    check("rst_fb_addr", {20'd0, fb_addr}, 32'd0);
    check("rst_fb_wdata", {24'd0, fb_wdata}, 32'd0);
    check("rst_ack", {29'd0, ack}, 32'd0);
    check("rst_clear_done", {31'd0, clear_done}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_err_oob", {31'd0, err_oob}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single request with exact one-cycle latency
    xs[0] = 8'd5; ys[0] = 8'd2; ds[0] = 8'hA7;
    exp_q.push_back(exp_of(0));
    req = 3'b001;
    @(negedge clk);
    check("single_ack", {29'd0, ack}, 32'b001);
    check("single_we", {31'd0, fb_we}, 32'd1);
    check("single_addr", {20'd0, fb_addr}, 32'd133);
    req = 3'b000;
    ptr = 1;
    repeat (3) @(negedge clk);
    check("single_one_write", exp_q.size(), 32'd0);

    // Contention, each requester drops on ack
    xs[0] = 8'd10; ys[0] = 8'd0; ds[0] = 8'h11;
    xs[1] = 8'd20; ys[1] = 8'd1; ds[1] = 8'h22;
    xs[2] = 8'd30; ys[2] = 8'd2; ds[2] = 8'h33;
    cur = 3'b111;
    req = cur;
    for (int g = 0; g < 3; g++) begin
      w = pick(cur, ptr);
      exp_q.push_back(exp_of(w));
      wait_ack(a);
      check("cont_ack", {29'd0, a}, 32'(1 << w));
      cur[w] = 1'b0;
      req = cur;
      ptr = (w + 1) % 3;
    end
    repeat (3) @(negedge clk);
    check("cont_three_writes", exp_q.size(), 32'd0);

    // req[1] and req[2] held across six grants
    cur = 3'b110;
    req = cur;
    for (int g = 0; g < 6; g++) begin
      w = pick(cur, ptr);
      exp_q.push_back(exp_of(w));
      wait_ack(a);
      check("held_ack", {29'd0, a}, 32'(1 << w));
      ptr = (w + 1) % 3;
    end
    req = 3'b000;
    repeat (3) @(negedge clk);
    check("held_writes", exp_q.size(), 32'd0);

    // Out of range on x, then on y: consumed, flagged, not written
    xs[1] = 8'd64; ys[1] = 8'd0; ds[1] = 8'hEE;
    req = 3'b010;
    wait_ack(a);
    check("oobx_ack", {29'd0, a}, 32'b010);
    check("oobx_err", {31'd0, err_oob}, 32'd1);
    check("oobx_we", {31'd0, fb_we}, 32'd0);
    req = 3'b000;
    ptr = 2;
    xs[2] = 8'd0; ys[2] = 8'd64; ds[2] = 8'hEE;
    @(negedge clk);
    req = 3'b100;
    wait_ack(a);
    check("ooby_ack", {29'd0, a}, 32'b100);
    check("ooby_err", {31'd0, err_oob}, 32'd1);
    check("ooby_we", {31'd0, fb_we}, 32'd0);
    req = 3'b000;
    ptr = 0;
    @(negedge clk);
    check("oob_err_pulse", {31'd0, err_oob}, 32'd0);

    // Clear colliding with a request; a second clear_start mid-sweep
    xs[0] = 8'd1; ys[0] = 8'd1; ds[0] = 8'h55;
    for (int i = 0; i < 4096; i++) exp_q.push_back('{addr: 12'(i), data: 8'h00});
    exp_q.push_back(exp_of(0));
    clear_start = 1'b1;
    req = 3'b001;
    @(negedge clk);
    clear_start = 1'b0;
    check("clr_busy_start", {31'd0, busy}, 32'd1);
    check("clr_no_ack_start", {29'd0, ack}, 32'd0);
    nwr = 0; done_seen = 0; ack_in_clear = 0;
    for (int i = 0; i < 5000 && !done_seen; i++) begin
      @(negedge clk);
      clear_start = (i == 100);
      if (fb_we && busy) nwr++;
      if (ack != 3'b000) ack_in_clear = 1;
      if (clear_done) done_seen = 1;
    end
    clear_start = 1'b0;
    check("clr_done_seen", {31'd0, done_seen}, 32'd1);
    check("clr_write_count", nwr, 32'd4096);
    check("clr_no_ack", {31'd0, ack_in_clear}, 32'd0);
    check("clr_done_we", {31'd0, fb_we}, 32'd0);
    check("clr_done_busy", {31'd0, busy}, 32'd0);
    wait_ack(a);
    check("clr_then_ack", {29'd0, a}, 32'b001);
    req = 3'b000;
    ptr = 1;
    repeat (3) @(negedge clk);
    check("clr_sb_drained", exp_q.size(), 32'd0);

    // Reset while the sweep sits at address 1000
    for (int i = 0; i <= 1000; i++) exp_q.push_back('{addr: 12'(i), data: 8'h00});
    clear_start = 1'b1;
    @(negedge clk);
    clear_start = 1'b0;
    hit = 0;
    for (int i = 0; i < 2000 && !hit; i++) begin
      @(negedge clk);
      if (fb_we && fb_addr == 12'd1000) hit = 1;
    end
    check("rstclr_reached_1000", {31'd0, hit}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rstclr_we", {31'd0, fb_we}, 32'd0);
    check("rstclr_busy", {31'd0, busy}, 32'd0);
    check("rstclr_done", {31'd0, clear_done}, 32'd0);
    check("rstclr_addr", {20'd0, fb_addr}, 32'd0);
    rst = 1'b0;
    ptr = 0;
    @(negedge clk);
    check("rstclr_no_done", {31'd0, clear_done}, 32'd0);

    // Back in IDLE: corner pixel accepted with one-cycle latency
    xs[0] = 8'd63; ys[0] = 8'd63; ds[0] = 8'hFF;
    exp_q.push_back(exp_of(0));
    req = 3'b001;
    @(negedge clk);
    check("corner_ack", {29'd0, ack}, 32'b001);
    check("corner_err", {31'd0, err_oob}, 32'd0);
    req = 3'b000;
    repeat (3) @(negedge clk);
    check("final_sb_empty", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
